// File: rtl/sdram_sched_pkg.sv
// sdram_sched_pkg: shared types and constants for the SDRAM port scheduler
package sdram_sched_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE} state_t;
  localparam logic [1:0] PORT_WR1 = 2'd0;
  localparam logic [1:0] PORT_RD1 = 2'd1;
  localparam logic [1:0] PORT_RD2 = 2'd2;
  localparam int ADDR_W = 23;
  localparam int LEN_W = 9;
endpackage

// File: rtl/sched_addr_gen.sv
// sched_addr_gen: per-port burst address counter with wrap back to base
module sched_addr_gen
  import sdram_sched_pkg::*;
#(
  parameter int BASE  = 0,
  parameter int MAX   = 324480,
  parameter int BURST = 128
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              advance,
  input  logic              load,
  output logic [ADDR_W-1:0] addr
);
  localparam int AW1 = ADDR_W + 1;
  logic [ADDR_W:0] nxt;
  assign nxt = {1'b0, addr} + AW1'(BURST);
  always_ff @(posedge iCLK)
    if (iRST || load) addr <= ADDR_W'(BASE);
    else if (advance) addr <= nxt >= AW1'(MAX) ? ADDR_W'(BASE) : nxt[ADDR_W-1:0];
endmodule

// File: rtl/sdram_port_scheduler.sv
// sdram_port_scheduler: arbitrates one write and two read FIFO ports into SDRAM burst commands
module sdram_port_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int WR1_BASE  = 0,
  parameter int WR1_MAX   = 324480,
  parameter int RD1_BASE  = 8320,
  parameter int RD1_MAX   = 161920,
  parameter int RD2_BASE  = 170880,
  parameter int RD2_MAX   = 324480,
  parameter int BURST     = 128,
  parameter int RD_THRESH = 128,
  parameter int WR_STREAK = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iLOAD,
  input  logic [9:0]        iWR1_USEDW,
  input  logic [9:0]        iRD1_USEDW,
  input  logic [9:0]        iRD2_USEDW,
  output logic              oCMD_VALID,
  output logic              oCMD_WRITE,
  output logic [1:0]        oCMD_PORT,
  output logic [ADDR_W-1:0] oCMD_ADDR,
  output logic [LEN_W-1:0]  oCMD_LEN,
  input  logic              iCMD_READY,
  input  logic              iCMD_DONE,
  output logic              oBUSY
);
  localparam int SW = $clog2(WR_STREAK + 2);
  state_t state, state_n;
  logic [SW-1:0] streak, streak_n;
  logic pref_rd2, pref_n, skip, skip_n, valid_n, write_n, advance;
  logic wr_req, rd1_req, rd2_req, pick_wr;
  logic [1:0] port_n, pick_port;
  logic [ADDR_W-1:0] addr_n, pick_addr, addr_wr, addr_rd1, addr_rd2;
  logic [LEN_W-1:0] len_n;
  assign wr_req = 32'(iWR1_USEDW) >= BURST;
  assign rd1_req = 32'(iRD1_USEDW) < RD_THRESH;
  assign rd2_req = 32'(iRD2_USEDW) < RD_THRESH;
  assign pick_wr = wr_req && !(streak == SW'(WR_STREAK) && (rd1_req || rd2_req));
  assign pick_port = pick_wr ? PORT_WR1 : (rd1_req && (!rd2_req || !pref_rd2)) ? PORT_RD1 : PORT_RD2;
  assign pick_addr = pick_port == PORT_WR1 ? addr_wr : pick_port == PORT_RD1 ? addr_rd1 : addr_rd2;
  assign oBUSY = state != IDLE;
  // skip marks a burst whose address was reloaded mid-flight, so its DONE must not advance
  always_comb begin
    state_n = state;
    valid_n = oCMD_VALID;
    write_n = oCMD_WRITE;
    port_n = oCMD_PORT;
    addr_n = oCMD_ADDR;
    len_n = oCMD_LEN;
    streak_n = iLOAD ? '0 : streak;
    pref_n = iLOAD ? 1'b0 : pref_rd2;
    skip_n = skip;
    advance = 1'b0;
    case (state)
      IDLE: if (!iLOAD && (wr_req || rd1_req || rd2_req)) begin
        state_n = GRANT;
        valid_n = 1'b1;
        write_n = pick_wr;
        port_n = pick_port;
        addr_n = pick_addr;
        len_n = LEN_W'(BURST);
        skip_n = 1'b0;
        streak_n = !pick_wr ? '0 : streak == SW'(WR_STREAK) ? streak : streak + 1'b1;
        pref_n = pick_wr ? pref_rd2 : pick_port == PORT_RD1;
      end
      GRANT: if (iCMD_READY || iLOAD) begin
        state_n = iCMD_READY ? WAIT_DONE : IDLE;
        valid_n = 1'b0;
        skip_n = iLOAD;
      end
      WAIT_DONE: begin
        skip_n = skip || iLOAD;
        if (iCMD_DONE) begin
          state_n = IDLE;
          advance = !iLOAD && !skip;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge iCLK)
    if (iRST) begin
      state <= IDLE;
      oCMD_VALID <= 1'b0;
      oCMD_WRITE <= 1'b0;
      oCMD_PORT <= '0;
      oCMD_ADDR <= '0;
      oCMD_LEN <= '0;
      streak <= '0;
      pref_rd2 <= 1'b0;
      skip <= 1'b0;
    end else begin
      state <= state_n;
      oCMD_VALID <= valid_n;
      oCMD_WRITE <= write_n;
      oCMD_PORT <= port_n;
      oCMD_ADDR <= addr_n;
      oCMD_LEN <= len_n;
      streak <= streak_n;
      pref_rd2 <= pref_n;
      skip <= skip_n;
    end
  sched_addr_gen #(.BASE(WR1_BASE), .MAX(WR1_MAX), .BURST(BURST)) u_wr1 (
    .iCLK(iCLK), .iRST(iRST), .advance(advance && oCMD_PORT == PORT_WR1), .load(iLOAD), .addr(addr_wr));
  sched_addr_gen #(.BASE(RD1_BASE), .MAX(RD1_MAX), .BURST(BURST)) u_rd1 (
    .iCLK(iCLK), .iRST(iRST), .advance(advance && oCMD_PORT == PORT_RD1), .load(iLOAD), .addr(addr_rd1));
  sched_addr_gen #(.BASE(RD2_BASE), .MAX(RD2_MAX), .BURST(BURST)) u_rd2 (
    .iCLK(iCLK), .iRST(iRST), .advance(advance && oCMD_PORT == PORT_RD2), .load(iLOAD), .addr(addr_rd2));
endmodule
